// File: rtl/pci_pkg.sv
// Shared definitions for the central PCI bus arbiter: FSM states and active-low signal levels.
package pci_pkg;

  typedef enum logic [1:0] {
    ST_PARK,
    ST_GAP,
    ST_GRANT,
    ST_BUSY
  } arb_state_e;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: first active-low request at or after ptr, wrapping modulo N_MASTERS.
module pci_rr_picker
  import pci_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] ptr,
  output logic                         valid,
  output logic [$clog2(N_MASTERS)-1:0] winner
);

  localparam int unsigned IW = $clog2(N_MASTERS);

  logic [IW:0] slot;

  // One spare bit lets ptr+k exceed N-1 before the single wrap subtraction.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    slot   = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      slot = {1'b0, ptr} + (IW+1)'(k);
      if (slot >= (IW+1)'(N_MASTERS)) slot = slot - (IW+1)'(N_MASTERS);
      if (!valid && req[slot[IW-1:0]] == ASSERTED) begin
        valid  = 1'b1;
        winner = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin grant, bus parking, grant timeout and hidden arbitration.
module pci_bus_arbiter
  import pci_pkg::*;
#(
  parameter int unsigned N_MASTERS   = 4,
  parameter int unsigned PARK_MASTER = 0,
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req,
  input  logic                         frame,
  input  logic                         irdy,
  output logic [N_MASTERS-1:0]         gnt,
  output logic [$clog2(N_MASTERS)-1:0] owner,
  output logic                         busy
);

  localparam int unsigned   IW       = $clog2(N_MASTERS);
  localparam int unsigned   CW       = $clog2(GNT_TIMEOUT + 1);
  localparam logic [IW-1:0] PARK_IDX = IW'(PARK_MASTER);
  localparam logic [CW-1:0] TMAX     = CW'(GNT_TIMEOUT);

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] gnt_d, own_mask;
  logic [IW-1:0]        owner_d, rr_q, rr_d, owner_inc, pick_idx;
  logic [CW-1:0]        tcnt_q, tcnt_d, tcnt_inc;
  logic                 busy_d, idle_q, bus_idle, start, pick_valid, other_req;

  function automatic logic [N_MASTERS-1:0] grant_vec(input logic [IW-1:0] idx);
    grant_vec      = '1;
    grant_vec[idx] = ASSERTED;
  endfunction

  pci_rr_picker #(.N_MASTERS(N_MASTERS)) u_picker (
    .req    (req),
    .ptr    (rr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign bus_idle  = frame & irdy;
  // A transaction starts only when FRAME# falls after an idle edge, so a hidden-arbitration
  // grantee never mistakes the previous owner's running transfer for its own start.
  assign start     = (frame == ASSERTED) && idle_q;
  assign owner_inc = (owner == IW'(N_MASTERS - 1)) ? '0 : owner + IW'(1);
  assign tcnt_inc  = (tcnt_q == TMAX) ? tcnt_q : tcnt_q + CW'(1);
  assign other_req = |(~req & ~own_mask);

  always_comb begin
    own_mask        = '0;
    own_mask[owner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '1;
    owner_d = owner;
    rr_d    = rr_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_PARK: begin
        gnt_d   = grant_vec(PARK_IDX);
        owner_d = PARK_IDX;
        if (start) begin
          state_d = ST_BUSY;
        end else if (pick_valid) begin
          if (pick_idx == PARK_IDX) begin
            state_d = ST_GRANT;
            tcnt_d  = '0;
          end else begin
            state_d = ST_GAP;
            gnt_d   = '1;
          end
        end
      end
      ST_GAP: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          gnt_d   = grant_vec(pick_idx);
          tcnt_d  = '0;
        end else begin
          state_d = ST_PARK;
          owner_d = PARK_IDX;
          gnt_d   = grant_vec(PARK_IDX);
        end
      end
      ST_GRANT: begin
        gnt_d = grant_vec(owner);
        if (start) begin
          state_d = ST_BUSY;
          rr_d    = owner_inc;
        end else if (req[owner] == DEASSERTED) begin
          state_d = ST_GAP;
          gnt_d   = '1;
        end else if (bus_idle) begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TMAX) begin
            state_d = ST_GAP;
            gnt_d   = '1;
            rr_d    = owner_inc;
          end
        end
      end
      ST_BUSY: begin
        gnt_d = grant_vec(owner);
        if (other_req || (bus_idle && owner != PARK_IDX)) begin
          state_d = ST_GAP;
          gnt_d   = '1;
        end else if (bus_idle) begin
          state_d = ST_PARK;
        end
      end
      default: state_d = ST_PARK;
    endcase
  end

  assign busy_d = (state_d == ST_BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PARK;
      gnt     <= '1;
      owner   <= PARK_IDX;
      busy    <= 1'b0;
      rr_q    <= '0;
      tcnt_q  <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      busy    <= busy_d;
      rr_q    <= rr_d;
      tcnt_q  <= tcnt_d;
      idle_q  <= bus_idle;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Bench for pci_bus_arbiter: directed protocol checks plus randomized request rounds scored by a grant-order model.
module tb_pci_bus_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         frame;
  logic         irdy;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;

  int           total = 0;
  int           bad   = 0;
  int unsigned  exp_q[$];
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  pci_bus_arbiter #(.N_MASTERS(N), .PARK_MASTER(0), .GNT_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .frame (frame),
    .irdy  (irdy),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: every new grant (a low gnt bit appearing) must match the next queued expectation.
  initial begin
    logic [N-1:0] prev;
    int unsigned  idx;
    int unsigned  e;
    prev = '1;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("onehot_gnt", ($countones(~gnt) <= 1), 1);
        if (gnt != '1 && gnt != prev) begin
          check("gap_before_grant", prev, 4'b1111);
          idx = 0;
          for (int unsigned j = 0; j < N; j++) if (gnt[j] == 1'b0) idx = j;
          if (exp_q.size() == 0) begin
            check("unexpected_grant", idx, 99);
          end else begin
            e = exp_q.pop_front();
            check("grant_order", idx, e);
            check("owner_tracks_gnt", owner, e);
          end
        end
      end
      prev = gnt;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          guard;
    int unsigned ptr_model;
    int unsigned last;
    int unsigned i;
    int unsigned left;
    int unsigned phase;
    bit          first;
    logic [N-1:0] rset;
    logic [N-1:0] pending;

    rst = 1'b0; req = '1; frame = 1'b1; irdy = 1'b1;
    repeat (3) tick();
    check("reset_gnt", gnt, 4'b1111);
    check("reset_owner", owner, 0);
    check("reset_busy", busy, 0);
    rst = 1'b1;
    tick();
    check("park_gnt", gnt, 4'b1110);
    check("park_owner", owner, 0);

    // m2 alone from park: one gap, grant, transaction, then tie m0/m3 goes to m3
    req = 4'b1011; tick();
    check("t2_gap", gnt, 4'b1111);
    tick();
    check("t2_grant", gnt, 4'b1011);
    check("t2_owner", owner, 2);
    frame = 1'b0; irdy = 1'b0; req = '1; tick();
    check("t2_busy", busy, 1);
    check("t2_hold", gnt, 4'b1011);
    req = 4'b0110; frame = 1'b1; tick();
    check("t2_release", gnt, 4'b1111);
    irdy = 1'b1; tick();
    check("t2_tie_m3", gnt, 4'b0111);
    req = '1; tick(); tick();
    check("t2_repark", gnt, 4'b1110);

    // m1 granted on an idle bus but never starts
    req = 4'b1101; tick();
    check("t4_gap0", gnt, 4'b1111);
    tick();
    check("t4_grant", gnt, 4'b1101);
    req = 4'b0101; n = 1; guard = 0;
    tick();
    while (gnt == 4'b1101 && guard < 40) begin
      n++; guard++; tick();
    end
    check("t4_timeout_len", n, 16);
    check("t4_gap", gnt, 4'b1111);
    tick();
    check("t4_next_m3", gnt, 4'b0111);
    req = '1; tick(); tick();
    check("t4_repark", gnt, 4'b1110);

    // hidden arbitration: m3 granted during m0's transfer, starts only after bus idle
    req = 4'b1110; tick();
    check("t5_park_grant", gnt, 4'b1110);
    frame = 1'b0; irdy = 1'b0; req = '1; tick();
    check("t5_busy", busy, 1);
    req = 4'b0111; tick();
    check("t5_gap", gnt, 4'b1111);
    tick();
    check("t5_hidden_grant", gnt, 4'b0111);
    check("t5_not_started", busy, 0);
    frame = 1'b1; tick();
    check("t5_last_phase", busy, 0);
    irdy = 1'b1; tick();
    check("t5_idle", busy, 0);
    frame = 1'b0; irdy = 1'b0; req = '1; tick();
    check("t5_start", busy, 1);
    check("t5_owner", owner, 3);

    // reset while busy
    #2 rst = 1'b0;
    #1;
    check("t6_async_gnt", gnt, 4'b1111);
    check("t6_async_busy", busy, 0);
    check("t6_async_owner", owner, 0);
    tick();
    frame = 1'b1; irdy = 1'b1; rst = 1'b1;
    tick();
    check("t6_repark", gnt, 4'b1110);

    // random rounds: requesters are served in cyclic order from the master after the last starter
    ptr_model = 0;
    mon_en = 1'b1;
    for (int unsigned r = 0; r < 40; r++) begin
      rset = (r == 0) ? 4'b1111 : 4'($urandom_range(1, 15));
      first = 1'b1; last = 0;
      for (int unsigned k = 0; k < N; k++) begin
        i = (ptr_model + k) % N;
        if (rset[i]) begin
          if (!(first && i == 0)) exp_q.push_back(i);
          first = 1'b0;
          last = i;
        end
      end
      if (last != 0) exp_q.push_back(0);
      ptr_model = (last + 1) % N;

      req = ~rset; pending = rset; phase = 0; left = 0;
      tick();
      guard = 0;
      while ((pending != '0 || phase != 0) && guard < 200) begin
        guard++;
        case (phase)
          1: begin
            if (left > 1) left--;
            else begin frame = 1'b1; phase = 2; end
          end
          2: begin
            irdy = 1'b1; phase = 0;
          end
          default: begin
            for (int unsigned j = 0; j < N; j++) begin
              if (phase == 0 && pending[j] && gnt[j] == 1'b0) begin
                frame = 1'b0; irdy = 1'b0; req[j] = 1'b1; pending[j] = 1'b0;
                left = $urandom_range(1, 3); phase = 1;
              end
            end
          end
        endcase
        tick();
      end
      check("round_done", (guard < 200), 1);
      frame = 1'b1; irdy = 1'b1; req = '1;
      repeat (4) tick();
      check("round_grants_seen", exp_q.size(), 0);
      exp_q.delete();
    end
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
